// File: rtl/fpu_sp_pkg.sv
// Shared single-precision FP types and constants.
// Used by the subtractor pipeline and its helpers.
package fpu_sp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 23;
  localparam int GRD_W    = 3;
  localparam int ALN_W    = MANT_W + 1 + GRD_W;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
  } fp_unp_t;

  typedef struct packed {
    logic             vld;
    logic             nan;
    logic             sign;
    logic             sub;
    logic [7:0]       exp;
    logic [ALN_W-1:0] ma;
    logic [ALN_W-1:0] mb;
  } s1_t;

  typedef struct packed {
    logic           vld;
    logic           nan;
    logic           sign;
    logic [7:0]     exp;
    logic [ALN_W:0] sum;
  } s2_t;

  function automatic fp_unp_t fp_unpack(input logic [31:0] x);
    fp_unp_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.mant = (x[30:23] == 8'h00) ? 24'h0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fpu_sp_lzc.sv
// Leading-zero counter over the 25-bit normalize window.
// All-zero input reports 25.
module fpu_sp_lzc (
  input  logic [24:0] i_val,
  output logic [4:0]  o_cnt
);

  // highest set bit wins; scan low to high
  always_comb begin
    o_cnt = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (i_val[i]) o_cnt = 5'(24 - i);
    end
  end

endmodule

// File: rtl/fpu_sp_subtractor.sv
// Pipelined single-precision a - b, truncating.
// S1 align, S2 add/sub, S3 normalize/pack/flags.
module fpu_sp_subtractor
  import fpu_sp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow
);

  localparam logic signed [9:0] EXP_SAT = 10'(EXP_MAX);

  fp_unp_t w_ua, w_ub, w_big, w_sml;
  logic             w_nan, w_swap, w_stall;
  logic [7:0]       w_diff;
  logic [ALN_W-1:0] w_mb_al;
  s1_t              r_s1;
  s2_t              r_s2;
  logic [ALN_W:0]   w_sum;
  logic [4:0]       w_cnt;
  logic [ALN_W-1:0] w_shl;
  logic             w_carry, w_zero;
  logic signed [9:0] w_exp_n;
  logic [MANT_W-1:0] w_frac;
  logic [31:0]      w_res;
  logic             w_ov, w_un;
  logic [31:0]      r_result;
  logic             r_vld, r_ov, r_un;
  logic             w_unused;

  assign w_stall  = r_vld & ~out_ready;
  assign in_ready = ~w_stall;

  assign w_ua   = fp_unpack(a);
  assign w_ub   = fp_unpack({~b[31], b[30:0]});
  assign w_nan  = (&a[30:23]) | (&b[30:23]);
  assign w_swap = {w_ub.exp, w_ub.mant} >
                  {w_ua.exp, w_ua.mant};
  assign w_big  = w_swap ? w_ub : w_ua;
  assign w_sml  = w_swap ? w_ua : w_ub;
  assign w_diff = w_big.exp - w_sml.exp;
  assign w_mb_al = (w_diff >= 8'd26) ? '0 :
    ({w_sml.mant, {GRD_W{1'b0}}} >> w_diff);

  // S1: register aligned operands, larger first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
    end else if (!w_stall) begin
      r_s1.vld  <= in_valid;
      r_s1.nan  <= w_nan;
      r_s1.sign <= w_big.sign;
      r_s1.sub  <= w_big.sign ^ w_sml.sign;
      r_s1.exp  <= w_big.exp;
      r_s1.ma   <= {w_big.mant, {GRD_W{1'b0}}};
      r_s1.mb   <= w_mb_al;
    end
  end

  assign w_sum = r_s1.sub ?
    ({1'b0, r_s1.ma} - {1'b0, r_s1.mb}) :
    ({1'b0, r_s1.ma} + {1'b0, r_s1.mb});

  // S2: register magnitude sum with carry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2 <= '0;
    end else if (!w_stall) begin
      r_s2.vld  <= r_s1.vld;
      r_s2.nan  <= r_s1.nan;
      r_s2.sign <= r_s1.sign;
      r_s2.exp  <= r_s1.exp;
      r_s2.sum  <= w_sum;
    end
  end

  // window is 24 mantissa bits plus top guard bit
  fpu_sp_lzc u_lzc (
    .i_val (r_s2.sum[26:2]),
    .o_cnt (w_cnt)
  );

  assign w_carry = r_s2.sum[ALN_W];
  assign w_zero  = (r_s2.sum == '0);
  assign w_shl   = r_s2.sum[ALN_W-1:0] << w_cnt;
  assign w_exp_n = w_carry ?
    ($signed({2'b00, r_s2.exp}) + 10'sd1) :
    ($signed({2'b00, r_s2.exp}) -
     $signed({5'd0, w_cnt}));
  assign w_frac  = w_carry ? r_s2.sum[26:4]
                           : w_shl[25:3];
  assign w_unused = ^{w_shl[26], w_shl[2:0]};

  // S3 combinational pack with special cases
  always_comb begin
    w_res = {r_s2.sign, w_exp_n[7:0], w_frac};
    w_ov  = 1'b0;
    w_un  = 1'b0;
    if (r_s2.nan) begin
      w_res = QNAN;
    end else if (w_zero) begin
      w_res = '0;
    end else if (w_exp_n >= EXP_SAT) begin
      w_res = {r_s2.sign, 8'hFF, 23'h0};
      w_ov  = 1'b1;
    end else if (w_exp_n <= 10'sd0) begin
      w_res = {r_s2.sign, 31'h0};
      w_un  = 1'b1;
    end
  end

  // S3: output register, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= 1'b0;
      r_result <= '0;
      r_ov     <= 1'b0;
      r_un     <= 1'b0;
    end else if (!w_stall) begin
      r_vld    <= r_s2.vld;
      r_result <= w_res;
      r_ov     <= w_ov;
      r_un     <= w_un;
    end
  end

  assign out_valid = r_vld;
  assign result    = r_result;
  assign overflow  = r_ov;
  assign underflow = r_un;

endmodule

// File: tb/tb_fpu_sp_subtractor.sv
// Self-checking bench for fpu_sp_subtractor.
// Scoreboard queue fed on input transfer.
module tb_fpu_sp_subtractor;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic        out_valid, out_ready;
  logic        overflow, underflow;
  logic [31:0] a, b, result;

  always #5 clk = ~clk;

  fpu_sp_subtractor #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        un;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
    logic        u;
  } vec_t;

  localparam int NV = 14;
  localparam vec_t VT [NV] = '{
    '{32'h40F00000, 32'h3F000000, 32'h40E00000, 1'b0, 1'b0},
    '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0},
    '{32'h7F26428A, 32'hFF26428A, 32'h7F800000, 1'b1, 1'b0},
    '{32'h00F0A5CF, 32'h00EF8F0C, 32'h00000000, 1'b0, 1'b1},
    '{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0},
    '{32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 1'b0},
    '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0},
    '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0},
    '{32'h00000001, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0},
    '{32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0, 1'b0},
    '{32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 1'b0},
    '{32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 1'b0, 1'b0},
    '{32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1, 1'b0},
    '{32'h3F800000, 32'h7FC00001, 32'h7FC00000, 1'b0, 1'b0}
  };

  exp_t q[$];
  exp_t drv_exp;
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;

  // scoreboard: push on accept, pop on output
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready)
      q.push_back(drv_exp);
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got %h ov=%b un=%b, required no output",
                 result, overflow, underflow);
      end else begin
        mon_e = q.pop_front();
        n_pop++;
        if ({result, overflow, underflow} !==
            {mon_e.res, mon_e.ov, mon_e.un}) begin
          n_fail++;
          $display("FAIL sb_result: got %h ov=%b un=%b, required %h ov=%b un=%b",
                   result, overflow, underflow,
                   mon_e.res, mon_e.ov, mon_e.un);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic drive(input int i);
    a        = VT[i].a;
    b        = VT[i].b;
    drv_exp  = '{VT[i].r, VT[i].o, VT[i].u};
    in_valid = 1'b1;
  endtask

  task automatic drain();
    int cyc = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0",
               q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    drv_exp   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out_valid: got %b, required 0", out_valid);
    end
    n_tests++;
    if (result !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_result: got %h, required 0", result);
    end
    n_tests++;
    if ({overflow, underflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_flags: got %b%b, required 00",
               overflow, underflow);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int cyc;
    bit seen;
    out_ready = 1'b1;
    drive(0);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_accept: got in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 20) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (!seen || cyc != 3) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles (seen=%b), required 3",
               cyc, seen);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(i);
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL arith_in_ready[%0d]: got %b, required 1",
                 i, in_ready);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int   idx = 0;
    int   cyc = 0;
    int   n_stall = 0;
    int   p0 = n_pop;
    bit   stall;
    bit   prev_stall = 1'b0;
    exp_t held = '0;
    while (idx < 8 && cyc < 100) begin
      drive(idx);
      out_ready = !(cyc >= 4 && cyc < 8);
      @(negedge clk);
      stall = out_valid && !out_ready;
      if (stall) begin
        n_stall++;
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: got %b, required 0", in_ready);
        end
        if (prev_stall) begin
          n_tests++;
          if ({result, overflow, underflow} !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got %h, required %h",
                     {result, overflow, underflow}, held);
          end
        end
        held = '{result, overflow, underflow};
      end
      prev_stall = stall;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (idx != 8 || n_stall != 4) begin
      n_fail++;
      $display("FAIL b2b_progress: got sent=%0d stalls=%0d, required 8 and 4",
               idx, n_stall);
    end
    drain();
    n_tests++;
    if (n_pop - p0 != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 8",
               n_pop - p0);
    end
  endtask

  task automatic test_reset_midflight();
    int cyc;
    bit seen;
    out_ready = 1'b1;
    drive(4);
    @(negedge clk);
    @(posedge clk); #1;
    drive(5);
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_rst_flush[%0d]: got out_valid=%b, required 0",
                 i, out_valid);
      end
      @(posedge clk); #1;
    end
    drive(9);
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 20) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (!seen || cyc != 3) begin
      n_fail++;
      $display("FAIL mid_rst_latency: got %0d cycles (seen=%b), required 3",
               cyc, seen);
    end
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
